instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
IF-stage fetch unit that produces the instruction word consumed by ID-stage decode.
- Holds the PC and issues in-order word requests to instruction memory over a valid/ready request channel.
- Buffers returned words with their PCs and presents one {pc, instruction} pair per cycle to ID.
- Handles stall (ID not ready) and redirect (branch/jump taken), and discards responses fetched on the wrong path.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 2, max in-flight requests plus buffered words; power of two, >=2

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  32  word-aligned fetch address
imem_rsp_valid  input  1  response word valid; responses are in request order, at least 1 cycle after acceptance
imem_rsp_data  input  32  fetched instruction word
redirect_valid  input  1  taken branch/jump from EX; flush and refetch
redirect_pc  input  32  redirect target
id_ready  input  1  ID can accept the current output (0 = stall)
if_valid  output  1  if_pc/if_instruction valid
if_pc  output  32  PC of presented instruction
if_instruction  output  32  presented instruction; NOP when if_valid=0

Behaviour:
- Reset (rst_n=0 at edge):
  - pc <= RESET_PC; outstanding, drop, FIFO count <= 0.
  - Outputs next cycle: imem_req_valid=0 during the reset cycle, if_valid=0, if_pc=RESET_PC, if_instruction=32'h0000_0013 (NOP).
  - Reset mid-operation discards all in-flight state. Responses still owed by memory for pre-reset requests are the memory's responsibility and must not arrive after reset.
- Credit: credit = DEPTH - outstanding - count.
- Request issue:
  - imem_req_valid = rst_n && !redirect_valid && credit>0.
  - imem_req_addr = pc.
  - The request may be withdrawn without handshake; memory samples only on valid&&ready.
- Request accept (valid&&ready): pc <= pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0x0); outstanding += 1.
- Response:
  - Each imem_rsp_valid decrements outstanding.
  - If drop>0: drop -= 1 and the word is discarded.
  - Otherwise push {pc_tag, data} into FIFO. pc_tag comes from a DEPTH-entry in-order tag queue written at request accept.
  - Pushed word visible on if_valid next cycle (1-cycle registered latency from rsp to ID).
- Output: if_valid = count>0; if_pc/if_instruction = FIFO head. Pop on if_valid && id_ready.
- Stall: id_ready=0 holds if_pc/if_instruction stable. Fetching continues until credit=0.
- Simultaneous push and pop while full: legal; count unchanged. Credit guarantees no overflow.
- Redirect (priority over everything else that cycle):
  - pc <= {redirect_pc[31:2],2'b00}.
  - FIFO and tag queue flushed (count <= 0); any pop that cycle is ignored.
  - drop <= outstanding minus 1 if a non-dropped response arrives the same cycle. Drop already pending carries over.
  - if_valid=0 on the next cycle.
  - No request is issued in the redirect cycle; the first target request is issued the cycle after.
- Back-to-back redirects: the latest wins; drop accumulates correctly.
- imem_rsp_valid with outstanding==0: protocol violation, ignored, counters unchanged (saturate at 0).
- Throughput: 1 instruction/cycle sustained when memory is ready every cycle with 1-cycle response latency and DEPTH>=2.

Decomposition:
- Shared defines header: NOP encoding 32'h0000_0013, default RESET_PC, XLEN=32.
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO of {pc[31:0], instr[31:0]} with flush, push, pop, count. Reused for the tag queue (instr field unused) or instantiated twice.
- Top handles PC, counters, credit, drop logic.

Test Plan:
- Reset release, memory ready every cycle, 1-cycle latency returning addr^0xA5 -> if_pc sequence 0x0,0x4,0x8,... with if_valid=1 every cycle from cycle 3. Data is correct and if_instruction is NOP before then.
- id_ready=0 for 5 cycles with DEPTH=2 -> exactly 2 requests outstanding/buffered, imem_req_valid=0, if_pc held. Release -> resumes with no duplicate or skipped PC.
- Redirect to 0x0000_0103 with 2 requests in flight -> both responses discarded, next if_pc=0x0000_0100, no wrong-path word ever shown with if_valid=1.
- Redirect in the same cycle as a response and a pop -> flush wins, if_valid=0 next cycle, drop count equals remaining in-flight requests.
- PC wrap: redirect to 0xFFFF_FFFC -> if_pc 0xFFFF_FFFC then 0x0000_0000.
- imem_req_ready toggling randomly with variable latency 1-4 cycles -> in-order PCs, no overflow, credit never negative.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared constants and types for the IF-stage fetch unit
package instr_fetch_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(3);
   endfunction
endpackage

// File: rtl/instr_fetch_fifo.sv
// rtl/instr_fetch_fifo.sv - DEPTH-entry synchronous FIFO with flush, used for fetched words and PC tags
module instr_fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 64,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  push_data_i,
   output logic [W-1:0]  head_data_o,
   output logic [CW-1:0] count_o
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   // A push into a full FIFO is accepted only when the head leaves in the same cycle.
   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && !flush_i && do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_data_o = mem_q[rd_ptr_q];
   assign count_o     = count_q;
endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - IF-stage fetch unit: PC, request credit, wrong-path drop and ID output buffer
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instruction
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] out_q, out_d, drop_q, drop_d;
   logic [CW-1:0] data_count, tag_count;
   logic [CW:0]   in_use;
   logic [31:0]   tag_head;
   fetch_entry_t  head, push_entry;
   logic          req_fire, rsp_eff, drop_hit, rsp_keep, pop;

   // Responses with nothing outstanding are protocol violations and are ignored.
   assign rsp_eff  = imem_rsp_valid && (out_q != '0);
   assign drop_hit = rsp_eff && (drop_q != '0);
   assign rsp_keep = rsp_eff && (drop_q == '0);
   assign if_valid = (data_count != '0);
   assign pop      = if_valid && id_ready && !redirect_valid;

   // A slot freed by this cycle's pop is reusable at once, which sustains one word per cycle.
   assign in_use         = {1'b0, out_q} + {1'b0, data_count} - (CW+1)'(pop);
   assign imem_req_valid = rst_n && !redirect_valid && (in_use < (CW+1)'(DEPTH));
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign push_entry = '{pc: tag_head, instr: imem_rsp_data};

   instr_fetch_fifo #(.DEPTH(DEPTH), .W(32)) u_tag_q (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (redirect_valid),
      .push_i      (req_fire),
      .pop_i       (rsp_keep && (tag_count != '0)),
      .push_data_i (pc_q),
      .head_data_o (tag_head),
      .count_o     (tag_count)
   );

   instr_fetch_fifo #(.DEPTH(DEPTH), .W(64)) u_data_q (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (redirect_valid),
      .push_i      (rsp_keep),
      .pop_i       (pop),
      .push_data_i (push_entry),
      .head_data_o (head),
      .count_o     (data_count)
   );

   assign if_pc          = if_valid ? head.pc    : pc_q;
   assign if_instruction = if_valid ? head.instr : NOP_INSTR;

   always_comb begin
      out_d  = out_q + CW'(req_fire) - CW'(rsp_eff);
      drop_d = drop_q - CW'(drop_hit);
      pc_d   = req_fire ? pc_q + 32'd4 : pc_q;
      if (redirect_valid) begin
         // Everything still owed by memory after this cycle belongs to the old path.
         pc_d   = word_align(redirect_pc);
         drop_d = out_q - CW'(rsp_eff);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q   <= RESET_PC;
         out_q  <= '0;
         drop_q <= '0;
      end else begin
         pc_q   <= pc_d;
         out_q  <= out_d;
         drop_q <= drop_d;
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch with a memory model and in-order scoreboard
module tb_instr_fetch;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instruction;

   instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instruction (if_instruction)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int due; } rsp_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

   rsp_t        mem_q[$];
   exp_t        exp_q[$];
   logic [31:0] model_pc;
   int          cyc, last_due, lat_min, lat_max, ready_pct;
   bit          spurious, rsp_real;
   int          checks, failures;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return addr ^ 32'h0000_00A5;
   endfunction

   // Advance one clock: sample at negedge, update memory model and expected stream, drive memory side.
   task automatic tick();
      bit s_rst, s_fire, s_redir, s_pop, s_valid, s_real;
      logic [31:0] s_addr, s_target, s_pc, s_instr;
      int lat, due;
      @(negedge clk);
      s_rst = rst_n; s_fire = imem_req_valid && imem_req_ready; s_addr = imem_req_addr;
      s_redir = redirect_valid; s_target = redirect_pc; s_real = rsp_real;
      s_pop = if_valid && id_ready && !redirect_valid;
      s_valid = if_valid; s_pc = if_pc; s_instr = if_instruction;
      if (s_rst) begin
         if (s_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL scoreboard: if_valid with pc=%h but no word expected", s_pc);
            end else if (s_pc !== exp_q[0].pc || s_instr !== exp_q[0].instr) begin
               failures++;
               $display("FAIL scoreboard: got pc=%h instr=%h expected pc=%h instr=%h",
                        s_pc, s_instr, exp_q[0].pc, exp_q[0].instr);
            end
         end
         checks++;
         if (mem_q.size() > DEPTH || exp_q.size() > DEPTH) begin
            failures++;
            $display("FAIL inflight: outstanding=%0d pending=%0d limit=%0d", mem_q.size(), exp_q.size(), DEPTH);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!s_rst) begin
         mem_q.delete(); exp_q.delete(); model_pc = RESET_PC; last_due = 0;
      end else begin
         if (s_pop && exp_q.size() > 0) void'(exp_q.pop_front());
         if (s_redir) begin
            exp_q.delete();
            model_pc = s_target & ~32'h3;
         end
         if (s_real && mem_q.size() > 0) void'(mem_q.pop_front());
         if (s_fire) begin
            checks++;
            if (s_addr !== model_pc) begin
               failures++;
               $display("FAIL req_addr: got %h expected %h", s_addr, model_pc);
            end
            lat = $urandom_range(lat_max, lat_min);
            due = cyc - 1 + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{addr: s_addr, due: due});
            exp_q.push_back('{pc: s_addr, instr: mem_word(s_addr)});
            model_pc = model_pc + 32'd4;
         end
      end
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(mem_q[0].addr); rsp_real = 1'b1;
      end else if (spurious) begin
         imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; rsp_real = 1'b0;
      end else begin
         imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; rsp_real = 1'b0;
      end
      imem_req_ready = ($urandom_range(99, 0) < ready_pct);
   endtask

   task automatic wait_valid(input int limit);
      for (int i = 0; i < limit && !if_valid; i++) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1; spurious = 1'b0;
      tick(); tick();
   endtask

   task automatic test_reset();
      lat_min = 1; lat_max = 1; ready_pct = 100;
      do_reset();
      checks++;
      if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
         failures++; $display("FAIL reset_valid: req_valid=%b if_valid=%b expected 0 0", imem_req_valid, if_valid);
      end
      checks++;
      if (if_pc !== RESET_PC) begin
         failures++; $display("FAIL reset_pc: got %h expected %h", if_pc, RESET_PC);
      end
      checks++;
      if (if_instruction !== NOP) begin
         failures++; $display("FAIL reset_nop: got %h expected %h", if_instruction, NOP);
      end
   endtask

   task automatic test_stream();
      rst_n = 1'b1;
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
         failures++; $display("FAIL first_req: valid=%b addr=%h expected 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
      end
      checks++;
      if (if_valid !== 1'b0 || if_instruction !== NOP) begin
         failures++; $display("FAIL early_nop: valid=%b instr=%h expected 0 %h", if_valid, if_instruction, NOP);
      end
      tick();
      checks++;
      if (if_valid !== 1'b0) begin
         failures++; $display("FAIL latency: if_valid=%b one cycle after release, expected 0", if_valid);
      end
      tick();
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (if_valid !== 1'b1) begin
            failures++; $display("FAIL throughput: if_valid=%b at stream cycle %0d expected 1", if_valid, i);
         end
         tick();
      end
   endtask

   task automatic test_stall();
      logic [31:0] held;
      id_ready = 1'b0;
      held = if_pc;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (if_valid !== 1'b1 || if_pc !== held) begin
            failures++; $display("FAIL stall_hold: valid=%b pc=%h expected 1 %h", if_valid, if_pc, held);
         end
      end
      #1;
      checks++;
      if (imem_req_valid !== 1'b0 || exp_q.size() != DEPTH) begin
         failures++; $display("FAIL stall_credit: req_valid=%b pending=%0d expected 0 %0d", imem_req_valid, exp_q.size(), DEPTH);
      end
      id_ready = 1'b1;
      for (int i = 0; i < 10; i++) tick();
   endtask

   task automatic test_redirect();
      lat_min = 3; lat_max = 3;
      for (int i = 0; i < 20 && mem_q.size() != 2; i++) tick();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
      #1;
      checks++;
      if (imem_req_valid !== 1'b0 || mem_q.size() != 2) begin
         failures++; $display("FAIL redir_noreq: req_valid=%b inflight=%0d expected 0 2", imem_req_valid, mem_q.size());
      end
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (if_valid !== 1'b0) begin
         failures++; $display("FAIL redir_flush: if_valid=%b expected 0", if_valid);
      end
      wait_valid(40);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h0000_0100 || if_instruction !== mem_word(32'h100)) begin
         failures++; $display("FAIL redir_target: valid=%b pc=%h instr=%h expected 1 00000100 %h",
                              if_valid, if_pc, if_instruction, mem_word(32'h100));
      end
      for (int i = 0; i < 6; i++) tick();
   endtask

   task automatic test_back_to_back();
      lat_min = 1; lat_max = 1; id_ready = 1'b1;
      for (int i = 0; i < 20 && !(imem_rsp_valid && if_valid); i++) tick();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (if_valid !== 1'b0) begin
         failures++; $display("FAIL collide_flush: if_valid=%b expected 0", if_valid);
      end
      wait_valid(20);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h0000_0200) begin
         failures++; $display("FAIL collide_target: valid=%b pc=%h expected 1 00000200", if_valid, if_pc);
      end
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
      tick();
      redirect_pc = 32'h0000_0406;
      tick();
      redirect_valid = 1'b0;
      wait_valid(20);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h0000_0404) begin
         failures++; $display("FAIL b2b_target: valid=%b pc=%h expected 1 00000404", if_valid, if_pc);
      end
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      wait_valid(20);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC) begin
         failures++; $display("FAIL wrap_top: valid=%b pc=%h expected 1 fffffffc", if_valid, if_pc);
      end
      tick();
      wait_valid(20);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h0000_0000 || if_instruction !== mem_word(32'h0)) begin
         failures++; $display("FAIL wrap_zero: valid=%b pc=%h instr=%h expected 1 00000000 %h",
                              if_valid, if_pc, if_instruction, mem_word(32'h0));
      end
   endtask

   task automatic test_spurious();
      ready_pct = 0;
      do_reset();
      rst_n = 1'b1;
      tick(); tick();
      spurious = 1'b1;
      tick();
      spurious = 1'b0;
      tick();
      checks++;
      if (if_valid !== 1'b0) begin
         failures++; $display("FAIL spurious_rsp: if_valid=%b expected 0", if_valid);
      end
      ready_pct = 100;
      wait_valid(20);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== RESET_PC) begin
         failures++; $display("FAIL spurious_resume: valid=%b pc=%h expected 1 %h", if_valid, if_pc, RESET_PC);
      end
   endtask

   task automatic test_random();
      int shown;
      lat_min = 1; lat_max = 4; ready_pct = 60; shown = 0;
      for (int i = 0; i < 1500; i++) begin
         id_ready = ($urandom_range(9, 0) < 7);
         redirect_valid = ($urandom_range(99, 0) < 3);
         redirect_pc = $urandom();
         rst_n = !(i >= 700 && i < 702);
         if (if_valid && id_ready) shown++;
         tick();
      end
      redirect_valid = 1'b0; id_ready = 1'b1; rst_n = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      checks++;
      if (shown < 100) begin
         failures++; $display("FAIL random_progress: consumed=%0d expected at least 100", shown);
      end
   endtask

   initial begin
      checks = 0; failures = 0; cyc = 0; last_due = 0; model_pc = RESET_PC;
      rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1; spurious = 1'b0; rsp_real = 1'b0;
      lat_min = 1; lat_max = 1; ready_pct = 100;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_back_to_back();
      test_wrap();
      test_spurious();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
